// File: rtl/lcd_dcs_pkg.sv
// DCS opcodes and default geometry shared by the LCD framebuffer address generator.
package lcd_dcs_pkg;

  localparam logic [7:0] DCS_CASET = 8'h2A;
  localparam logic [7:0] DCS_PASET = 8'h2B;
  localparam logic [7:0] DCS_RAMWR = 8'h2C;

  localparam int unsigned DEF_H_RES  = 320;
  localparam int unsigned DEF_V_RES  = 240;
  localparam int unsigned DEF_ADDR_W = 17;

  // StBase: row_base is being built by repeated addition after a RAMWR.
  typedef enum logic {StRun, StBase} walk_st_e;

  function automatic logic is_win_cmd(logic [7:0] cmd);
    return (cmd == DCS_CASET) || (cmd == DCS_PASET);
  endfunction

endpackage

// File: rtl/lcd_fb_addr_gen_if.sv
// Strobe inputs from the LCD bus receiver and framebuffer write outputs.
interface lcd_fb_addr_gen_if import lcd_dcs_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic [7:0]        i_command;
  logic              i_command_latch;
  logic [7:0]        i_param;
  logic              i_param_latch;
  logic [15:0]       i_rgb565;
  logic              i_rgb565_latch;
  logic              o_fb_we;
  logic [ADDR_W-1:0] o_fb_addr;
  logic [15:0]       o_fb_data;
  logic              o_frame_done;
  logic [15:0]       o_win_sc;
  logic [15:0]       o_win_ec;
  logic [15:0]       o_win_sp;
  logic [15:0]       o_win_ep;

  modport master (
    output i_command, i_command_latch, i_param, i_param_latch, i_rgb565, i_rgb565_latch,
    input  o_fb_we, o_fb_addr, o_fb_data, o_frame_done, o_win_sc, o_win_ec, o_win_sp, o_win_ep
  );

  modport slave (
    input  i_command, i_command_latch, i_param, i_param_latch, i_rgb565, i_rgb565_latch,
    output o_fb_we, o_fb_addr, o_fb_data, o_frame_done, o_win_sc, o_win_ec, o_win_sp, o_win_ep
  );
endinterface

// File: rtl/lcd_win_param.sv
// Assembles the four CASET/PASET parameter bytes and holds the committed window.
module lcd_win_param import lcd_dcs_pkg::*; #(
  parameter int unsigned H_RES = DEF_H_RES,
  parameter int unsigned V_RES = DEF_V_RES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_rst_n,
  input  logic [7:0]  command,
  input  logic        command_latch,
  input  logic [7:0]  param,
  input  logic        param_latch,
  output logic [15:0] sc,
  output logic [15:0] ec,
  output logic [15:0] sp,
  output logic [15:0] ep
);
  localparam logic [15:0] DefEc = 16'(H_RES - 1);
  localparam logic [15:0] DefEp = 16'(V_RES - 1);

  logic [7:0]  cmd_q, cmd_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;
  logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;

  always_comb begin
    cmd_d  = cmd_q;
    idx_d  = idx_q;
    full_d = full_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    sc_d   = sc_q;
    ec_d   = ec_q;
    sp_d   = sp_q;
    ep_d   = ep_q;
    if (command_latch) begin
      cmd_d  = command;
      idx_d  = '0;
      full_d = 1'b0;
    end else if (param_latch && !full_q && is_win_cmd(cmd_q)) begin
      unique case (idx_q)
        2'd0: sh0_d = param;
        2'd1: sh1_d = param;
        2'd2: sh2_d = param;
        default: begin
          // full_q blocks any further bytes until the next command.
          full_d = 1'b1;
          if (cmd_q == DCS_CASET) begin
            sc_d = {sh0_q, sh1_q};
            ec_d = {sh2_q, param};
          end else begin
            sp_d = {sh0_q, sh1_q};
            ep_d = {sh2_q, param};
          end
        end
      endcase
      if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
    end
    if (!lcd_rst_n) begin
      cmd_d  = '0;
      idx_d  = '0;
      full_d = 1'b0;
      sh0_d  = '0;
      sh1_d  = '0;
      sh2_d  = '0;
      sc_d   = '0;
      ec_d   = DefEc;
      sp_d   = '0;
      ep_d   = DefEp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
      sh0_q  <= '0;
      sh1_q  <= '0;
      sh2_q  <= '0;
      sc_q   <= '0;
      ec_q   <= DefEc;
      sp_q   <= '0;
      ep_q   <= DefEp;
    end else begin
      cmd_q  <= cmd_d;
      idx_q  <= idx_d;
      full_q <= full_d;
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      sc_q   <= sc_d;
      ec_q   <= ec_d;
      sp_q   <= sp_d;
      ep_q   <= ep_d;
    end
  end

  assign sc = sc_q;
  assign ec = ec_q;
  assign sp = sp_q;
  assign ep = ep_q;

endmodule

// File: rtl/lcd_fb_addr_gen.sv
// Turns RAMWR pixel strobes into linear framebuffer writes inside the CASET/PASET window.
module lcd_fb_addr_gen import lcd_dcs_pkg::*; #(
  parameter int unsigned H_RES  = DEF_H_RES,
  parameter int unsigned V_RES  = DEF_V_RES,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input logic              i_clk,
  input logic              i_rst_n,
  input logic              i_lcd_rst_n,
  lcd_fb_addr_gen_if.slave bus
);
  localparam logic [15:0]       HRes16 = 16'(H_RES);
  localparam logic [15:0]       VRes16 = 16'(V_RES);
  localparam logic [ADDR_W-1:0] HResA  = ADDR_W'(H_RES);

  logic [15:0] win_sc, win_ec, win_sp, win_ep;

  lcd_win_param #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_win_param (
    .clk           (i_clk),
    .rst_n         (i_rst_n),
    .lcd_rst_n     (i_lcd_rst_n),
    .command       (bus.i_command),
    .command_latch (bus.i_command_latch),
    .param         (bus.i_param),
    .param_latch   (bus.i_param_latch),
    .sc            (win_sc),
    .ec            (win_ec),
    .sp            (win_sp),
    .ep            (win_ep)
  );

  walk_st_e          st_q, st_d;
  logic [15:0]       x_q, x_d, y_q, y_d, y_start_q, y_start_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, start_base_q, start_base_d;
  logic              skid_vld_q, skid_vld_d;
  logic [15:0]       skid_data_q, skid_data_d;
  logic              fb_we_q, fb_we_d, done_q, done_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]       fb_data_q, fb_data_d;
  logic              pix_strobe, pix_go;
  logic [15:0]       pix, steps;

  always_comb begin
    st_d         = st_q;
    x_d          = x_q;
    y_d          = y_q;
    y_start_d    = y_start_q;
    cnt_d        = cnt_q;
    row_base_d   = row_base_q;
    start_base_d = start_base_q;
    skid_vld_d   = skid_vld_q;
    skid_data_d  = skid_data_q;
    fb_we_d      = 1'b0;
    done_d       = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    pix_go       = 1'b0;
    pix          = '0;
    pix_strobe   = bus.i_rgb565_latch && !bus.i_command_latch;
    steps        = (win_sp > VRes16) ? VRes16 : win_sp;

    if (bus.i_command_latch) begin
      skid_vld_d = 1'b0;
      if (bus.i_command == DCS_RAMWR) begin
        x_d          = win_sc;
        y_d          = win_sp;
        y_start_d    = win_sp;
        row_base_d   = '0;
        start_base_d = '0;
        cnt_d        = steps;
        st_d         = (steps != 16'd0) ? StBase : StRun;
      end
    end else if (st_q == StBase) begin
      // Multiply SP*H_RES by repeated addition; one pixel may wait in the skid.
      row_base_d = row_base_q + HResA;
      cnt_d      = cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        st_d         = StRun;
        start_base_d = row_base_d;
      end
      if (pix_strobe && !skid_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = bus.i_rgb565;
      end
    end else begin
      if (skid_vld_q) begin
        pix_go      = 1'b1;
        pix         = skid_data_q;
        skid_vld_d  = pix_strobe;
        skid_data_d = bus.i_rgb565;
      end else if (pix_strobe) begin
        pix_go = 1'b1;
        pix    = bus.i_rgb565;
      end
    end

    if (pix_go) begin
      if ((x_q < HRes16) && (y_q < VRes16)) begin
        fb_we_d   = 1'b1;
        fb_addr_d = row_base_q + ADDR_W'(x_q);
        fb_data_d = pix;
      end
      if (x_q >= win_ec) begin
        x_d = win_sc;
        // Wrap to the row latched at RAMWR so y and row_base stay consistent.
        if (y_q >= win_ep) begin
          y_d        = y_start_q;
          row_base_d = start_base_q;
          done_d     = 1'b1;
        end else begin
          y_d        = y_q + 16'd1;
          row_base_d = row_base_q + HResA;
        end
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    if (!i_lcd_rst_n) begin
      st_d         = StRun;
      x_d          = '0;
      y_d          = '0;
      y_start_d    = '0;
      cnt_d        = '0;
      row_base_d   = '0;
      start_base_d = '0;
      skid_vld_d   = 1'b0;
      skid_data_d  = '0;
      fb_we_d      = 1'b0;
      done_d       = 1'b0;
      fb_addr_d    = '0;
      fb_data_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q         <= StRun;
      x_q          <= '0;
      y_q          <= '0;
      y_start_q    <= '0;
      cnt_q        <= '0;
      row_base_q   <= '0;
      start_base_q <= '0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      fb_we_q      <= 1'b0;
      done_q       <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      st_q         <= st_d;
      x_q          <= x_d;
      y_q          <= y_d;
      y_start_q    <= y_start_d;
      cnt_q        <= cnt_d;
      row_base_q   <= row_base_d;
      start_base_q <= start_base_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      fb_we_q      <= fb_we_d;
      done_q       <= done_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign bus.o_fb_we      = fb_we_q;
  assign bus.o_fb_addr    = fb_addr_q;
  assign bus.o_fb_data    = fb_data_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_win_sc     = win_sc;
  assign bus.o_win_ec     = win_ec;
  assign bus.o_win_sp     = win_sp;
  assign bus.o_win_ep     = win_ep;

endmodule

// File: tb/tb_lcd_fb_addr_gen.sv
// Vector table, corner-case sequences and randomized windows against a pixel-position model.
module tb_lcd_fb_addr_gen;
  localparam int HR = 320;
  localparam int VR = 240;

  logic clk = 1'b0;
  logic rst_n;
  logic lcd_rst_n;
  always #5 clk = ~clk;

  lcd_fb_addr_gen_if #(.ADDR_W(17)) bus ();

  lcd_fb_addr_gen #(
    .H_RES  (HR),
    .V_RES  (VR),
    .ADDR_W (17)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_lcd_rst_n (lcd_rst_n),
    .bus         (bus)
  );

  typedef enum int {KCmd, KPar, KPix, KIdle, KLrst} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] data;
    logic        exp_we;
    int          exp_addr;
    logic [15:0] exp_data;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: committed window and write position.
  int m_sc, m_ec, m_sp, m_ep, mx, my;

  function automatic void add(kind_e k, int d, logic we = 1'b0, int addr = 0, int dat = 0,
                              logic done = 1'b0);
    vec_t v;
    v.kind = k; v.data = 16'(d); v.exp_we = we; v.exp_addr = addr;
    v.exp_data = 16'(dat); v.exp_done = done;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus.i_command = c; bus.i_command_latch = 1'b1;
    cycle();
    bus.i_command_latch = 1'b0;
  endtask

  task automatic send_param(input logic [7:0] p);
    bus.i_param = p; bus.i_param_latch = 1'b1;
    cycle();
    bus.i_param_latch = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d);
    bus.i_rgb565 = d; bus.i_rgb565_latch = 1'b1;
    cycle();
    bus.i_rgb565_latch = 1'b0;
  endtask

  task automatic lcd_reset();
    lcd_rst_n = 1'b0;
    cycle();
    lcd_rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic we, input int addr, input logic [15:0] data,
                         input logic done);
    chk({tag, ".we"}, bus.o_fb_we, we);
    chk({tag, ".done"}, bus.o_frame_done, done);
    if (we) begin
      chk({tag, ".addr"}, bus.o_fb_addr, addr);
      chk({tag, ".data"}, bus.o_fb_data, data);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_ec = HR - 1; m_sp = 0; m_ep = VR - 1; mx = 0; my = 0;
  endtask

  task automatic model_pix(output logic we, output int addr, output logic done);
    we = (mx < HR) && (my < VR);
    addr = my * HR + mx;
    done = 1'b0;
    if (mx >= m_ec) begin
      mx = m_sc;
      if (my >= m_ep) begin my = m_sp; done = 1'b1; end
      else my = my + 1;
    end else mx = mx + 1;
  endtask

  task automatic send_window(input logic [7:0] cmd, input int s, input int e, input int n);
    logic [7:0] b [4];
    b[0] = s[15:8]; b[1] = s[7:0]; b[2] = e[15:8]; b[3] = e[7:0];
    send_cmd(cmd);
    for (int k = 0; k < n; k++) send_param((k < 4) ? b[k] : 8'($urandom));
  endtask

  initial begin
    vec_t        v;
    logic        ewe, edone, last_done, seen;
    int          eaddr, bad, s, e, n, npix, last_addr;
    logic [15:0] d;

    bus.i_command = '0; bus.i_command_latch = 1'b0; bus.i_param = '0;
    bus.i_param_latch = 1'b0; bus.i_rgb565 = '0; bus.i_rgb565_latch = 1'b0;
    rst_n = 1'b0; lcd_rst_n = 1'b1;
    #12;
    chk("rst.we", bus.o_fb_we, 0);
    chk("rst.addr", bus.o_fb_addr, 0);
    chk("rst.data", bus.o_fb_data, 0);
    chk("rst.done", bus.o_frame_done, 0);
    chk("rst.sc", bus.o_win_sc, 0);
    chk("rst.ec", bus.o_win_ec, HR - 1);
    chk("rst.sp", bus.o_win_sp, 0);
    chk("rst.ep", bus.o_win_ep, VR - 1);
    @(posedge clk); #1 rst_n = 1'b1;
    cycle();

    // Default window, three pixels at 0,1,2.
    add(KCmd, 'h2C);
    add(KPix, 'h1111, 1, 0, 'h1111); add(KPix, 'h2222, 1, 1, 'h2222);
    add(KPix, 'h3333, 1, 2, 'h3333);
    // 2x2 window at column 10, row 5.
    add(KCmd, 'h2A); add(KPar, 0); add(KPar, 10); add(KPar, 0); add(KPar, 11);
    add(KCmd, 'h2B); add(KPar, 0); add(KPar, 5); add(KPar, 0); add(KPar, 6);
    add(KCmd, 'h2C); add(KIdle, 8);
    add(KPix, 'hA001, 1, 1610, 'hA001); add(KPix, 'hA002, 1, 1611, 'hA002);
    add(KPix, 'hA003, 1, 1930, 'hA003); add(KPix, 'hA004, 1, 1931, 'hA004, 1);
    add(KPix, 'hA005, 1, 1610, 'hA005);
    // Three-byte CASET never commits.
    add(KLrst, 0);
    add(KCmd, 'h2A); add(KPar, 0); add(KPar, 5); add(KPar, 0);
    add(KCmd, 'h2C); add(KPix, 'hB001, 1, 0, 'hB001); add(KPix, 'hB002, 1, 1, 'hB002);
    // Window straddling the right edge: columns 320/321 suppressed.
    add(KLrst, 0);
    add(KCmd, 'h2A); add(KPar, 1); add(KPar, 'h3E); add(KPar, 1); add(KPar, 'h41);
    add(KCmd, 'h2C);
    add(KPix, 'hC001, 1, 318, 'hC001); add(KPix, 'hC002, 1, 319, 'hC002);
    add(KPix, 'hC003); add(KPix, 'hC004);
    add(KPix, 'hC005, 1, 638, 'hC005);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      case (v.kind)
        KCmd:  send_cmd(v.data[7:0]);
        KPar:  send_param(v.data[7:0]);
        KPix:  send_pix(v.data);
        KIdle: repeat (int'(v.data)) cycle();
        default: lcd_reset();
      endcase
      chk_out($sformatf("vec%0d", i), v.exp_we, v.exp_addr, v.exp_data, v.exp_done);
    end

    // Debug window outputs, and a fifth parameter byte is ignored.
    lcd_reset();
    send_window(8'h2A, 10, 11, 4);
    chk("win.sc", bus.o_win_sc, 10);
    chk("win.ec", bus.o_win_ec, 11);
    send_param(8'hFF);
    chk("win.ec_5th", bus.o_win_ec, 11);

    // Skid: first pixel during row_base build is kept, second is dropped.
    lcd_reset();
    send_window(8'h2B, 3, 239, 4);
    send_cmd(8'h2C);
    send_pix(16'hBEEF);
    chk("skid.busy_we1", bus.o_fb_we, 0);
    send_pix(16'hDEAD);
    chk("skid.busy_we2", bus.o_fb_we, 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      seen = bus.o_fb_we;
    end
    chk("skid.arrived", seen, 1);
    chk("skid.addr", bus.o_fb_addr, 960);
    chk("skid.data", bus.o_fb_data, 16'hBEEF);
    send_pix(16'h0102);
    chk_out("skid.next", 1, 961, 16'h0102, 0);

    // Command and pixel in the same cycle: command wins.
    lcd_reset();
    send_cmd(8'h2C);
    send_pix(16'h0001);
    send_pix(16'h0002);
    bus.i_command = 8'h2C; bus.i_command_latch = 1'b1;
    bus.i_rgb565 = 16'h9999; bus.i_rgb565_latch = 1'b1;
    cycle();
    bus.i_command_latch = 1'b0; bus.i_rgb565_latch = 1'b0;
    chk("simul.we", bus.o_fb_we, 0);
    send_pix(16'h1234);
    chk_out("simul.next", 1, 0, 16'h1234, 0);

    // Async reset during a write.
    send_pix(16'h5A5A);
    chk("arst.pre_we", bus.o_fb_we, 1);
    bus.i_rgb565 = 16'h6B6B; bus.i_rgb565_latch = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.we", bus.o_fb_we, 0);
    chk("arst.addr", bus.o_fb_addr, 0);
    bus.i_rgb565_latch = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    send_cmd(8'h2C);
    send_pix(16'h7777);
    chk_out("arst.after", 1, 0, 16'h7777, 0);

    // Randomized windows against the model.
    lcd_reset();
    model_reset();
    for (int t = 0; t < 12; t++) begin
      s = $urandom_range(0, 325);
      e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, s) : s + $urandom_range(0, 7);
      n = $urandom_range(3, 5);
      send_window(8'h2A, s, e, n);
      if (n >= 4) begin m_sc = s; m_ec = e; end
      s = $urandom_range(0, 243);
      e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, s) : s + $urandom_range(0, 3);
      n = $urandom_range(3, 5);
      send_window(8'h2B, s, e, n);
      if (n >= 4) begin m_sp = s; m_ep = e; end
      send_cmd(8'h2C);
      mx = m_sc; my = m_sp;
      repeat (((m_sp > VR) ? VR : m_sp) + 2) cycle();
      npix = $urandom_range(1, 30);
      for (int p = 0; p < npix; p++) begin
        d = 16'($urandom);
        model_pix(ewe, eaddr, edone);
        send_pix(d);
        chk_out($sformatf("rnd%0d.%0d", t, p), ewe, eaddr, d, edone);
      end
    end

    // Full default frame, then wrap to address 0.
    lcd_reset();
    send_cmd(8'h2C);
    bad = 0; last_addr = 0; last_done = 1'b0;
    for (int i = 0; i < HR * VR; i++) begin
      send_pix(16'(i));
      if (!(bus.o_fb_we === 1'b1 && bus.o_fb_addr === 17'(i) && bus.o_fb_data === 16'(i)
            && bus.o_frame_done === (i == HR * VR - 1))) bad++;
      last_addr = int'(bus.o_fb_addr);
      last_done = bus.o_frame_done;
    end
    chk("frame.stream_errors", bad, 0);
    chk("frame.last_addr", last_addr, HR * VR - 1);
    chk("frame.last_done", last_done, 1);
    send_pix(16'hF00D);
    chk_out("frame.wrap", 1, 0, 16'hF00D, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
